// File: rtl/pot_conditioner_pkg.sv
// ----------------------------------------------------------------------------
// pot_conditioner_pkg
// Shared definitions for the potentiometer conditioning path.
//   - FSM state encoding (2-bit) used by pot_conditioner.
//   - Default word width and sample-period exponent. SAMPLE_LOG2_DEF matches
//     the ADC's capacitor-divider conversion period so that each sample tick
//     sees at least one fresh conversion.
// ----------------------------------------------------------------------------
package pot_conditioner_pkg;

    localparam int OUTSIZE_DEF       = 16;
    localparam int SAMPLE_LOG2_DEF   = 19;
    localparam int AVG_LOG2_DEF      = 2;
    localparam int STABLE_CYCLES_DEF = 4;
    localparam int HYST_DEF          = 16;

    typedef enum logic [1:0] {
        WAIT  = 2'd0,
        ACC   = 2'd1,
        CHECK = 2'd2,
        EMIT  = 2'd3
    } pot_state_t;

endpackage

// File: rtl/pot_conditioner_bus_stabilizer.sv
// ----------------------------------------------------------------------------
// bus_stabilizer
// Takes a clean copy of a slow, quasi-static multi-bit bus that is driven from
// an unrelated clock. The bus is registered twice (cap0, cap1); a word is only
// accepted into `stable` once cap0 and cap1 have matched for STABLE_CYCLES
// consecutive comparisons, so a capture taken mid-transition is never passed
// on. While the bus keeps moving, `stable` holds its last accepted value.
//
// Ports
//   osc     in   1      clock
//   rst_n   in   1      asynchronous active-low reset
//   raw     in   WIDTH  asynchronous input bus
//   stable  out  WIDTH  last accepted, settled value (0 after reset)
//
// STABLE_CYCLES must be at least 1.
// ----------------------------------------------------------------------------
module bus_stabilizer #(
    parameter int WIDTH         = 16,
    parameter int STABLE_CYCLES = 4
) (
    input  logic             osc,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] raw,
    output logic [WIDTH-1:0] stable
);

    localparam int             CW      = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0]  CNT_MAX = CW'(STABLE_CYCLES);

    logic [WIDTH-1:0] cap0;
    logic [WIDTH-1:0] cap1;
    logic [CW-1:0]    stab_cnt;

    always_ff @(posedge osc or negedge rst_n) begin
        if (!rst_n) begin
            cap0     <= '0;
            cap1     <= '0;
            stab_cnt <= '0;
            stable   <= '0;
        end else begin
            cap0 <= raw;
            cap1 <= cap0;

            // Saturating run-length of identical consecutive captures.
            if (cap0 == cap1) begin
                if (stab_cnt != CNT_MAX) begin
                    stab_cnt <= stab_cnt + 1'b1;
                end
            end else begin
                stab_cnt <= '0;
            end

            if (stab_cnt == CNT_MAX) begin
                stable <= cap1;
            end
        end
    end

endmodule

// File: rtl/pot_conditioner.sv
// ----------------------------------------------------------------------------
// pot_conditioner
// Turns the potentiometer ADC's raw result word into a jitter-free control
// level for the osc-domain synth logic. The raw bus is settled by
// bus_stabilizer, sampled once per tick, averaged over 2^AVG_LOG2 samples and
// passed through a hysteresis window before it may move `level`.
//
// Ports
//   osc     in   1        system clock (49.152 MHz)
//   rst_n   in   1        asynchronous active-low reset
//   raw     in   OUTSIZE  ADC result, asynchronous to osc
//   level   out  OUTSIZE  conditioned pot value
//   valid   out  1        one-cycle pulse when `level` is (re)written
//   busy    out  1        high while a block is being accumulated
//
// State | meaning
// ------+--------------------------------------------------------------
// WAIT  | idle, accumulator cleared; first tick loads the first sample
// ACC   | adding one sample per tick until the block is complete
// CHECK | compare block average with `level` against the hysteresis
// EMIT  | new `level` presented with `valid` high for this one cycle
//
// A tick that lands in CHECK or EMIT is dropped; with SAMPLE_LOG2 >= 2 ticks
// are far enough apart that this cannot happen. valid rises two cycles after
// the tick carrying the last sample of a block.
// ----------------------------------------------------------------------------
module pot_conditioner
    import pot_conditioner_pkg::*;
#(
    parameter int OUTSIZE       = OUTSIZE_DEF,
    parameter int SAMPLE_LOG2   = SAMPLE_LOG2_DEF,
    parameter int AVG_LOG2      = AVG_LOG2_DEF,      // 0..6
    parameter int STABLE_CYCLES = STABLE_CYCLES_DEF,
    parameter int HYST          = HYST_DEF
) (
    input  logic               osc,
    input  logic               rst_n,
    input  logic [OUTSIZE-1:0] raw,
    output logic [OUTSIZE-1:0] level,
    output logic               valid,
    output logic               busy
);

    // Accumulator is wide enough for 2^AVG_LOG2 full-scale samples.
    localparam int              ACCW   = OUTSIZE + AVG_LOG2;
    localparam int              NW     = AVG_LOG2 + 1;
    localparam logic [NW-1:0]   N_LAST = NW'(1 << AVG_LOG2);
    localparam logic [OUTSIZE:0] HYST_W = (OUTSIZE + 1)'(HYST);

    logic [OUTSIZE-1:0]     stable;
    logic [SAMPLE_LOG2-1:0] tick_cnt;
    logic                   tick;

    pot_state_t             state, state_nx;
    logic [ACCW-1:0]        acc, acc_nx;
    logic [NW-1:0]          n, n_nx;
    logic [OUTSIZE-1:0]     level_nx;
    logic                   valid_nx;
    logic                   first, first_nx;

    logic [ACCW-1:0]        stable_ext;
    logic [OUTSIZE-1:0]     avg;
    logic [OUTSIZE:0]       diff;
    logic                   upd;

    bus_stabilizer #(
        .WIDTH         (OUTSIZE),
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_stab (
        .osc    (osc),
        .rst_n  (rst_n),
        .raw    (raw),
        .stable (stable)
    );

    // Free-running sample divider; tick marks the cycle the counter wraps.
    always_ff @(posedge osc or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    assign tick = (tick_cnt == '1);

    assign stable_ext = ACCW'(stable);
    assign avg        = acc[ACCW-1:AVG_LOG2];

    // Magnitude of the difference at OUTSIZE+1 bits so full-scale swings
    // (0x0000 vs 0xFFFF) do not wrap.
    always_comb begin
        if (avg >= level) begin
            diff = {1'b0, avg} - {1'b0, level};
        end else begin
            diff = {1'b0, level} - {1'b0, avg};
        end
    end

    assign upd = first || (diff > HYST_W);

    always_ff @(posedge osc or negedge rst_n) begin
        if (!rst_n) begin
            state <= WAIT;
            acc   <= '0;
            n     <= '0;
            level <= '0;
            valid <= 1'b0;
            first <= 1'b1;
        end else begin
            state <= state_nx;
            acc   <= acc_nx;
            n     <= n_nx;
            level <= level_nx;
            valid <= valid_nx;
            first <= first_nx;
        end
    end

    // level/valid/first are loaded on the CHECK->EMIT edge so that the new
    // level and its valid strobe are both visible during the EMIT cycle.
    always_comb begin
        state_nx = state;
        acc_nx   = acc;
        n_nx     = n;
        level_nx = level;
        valid_nx = 1'b0;
        first_nx = first;

        case (state)
            WAIT: begin
                acc_nx = '0;
                n_nx   = '0;
                if (tick) begin
                    acc_nx   = stable_ext;
                    n_nx     = NW'(1);
                    state_nx = (AVG_LOG2 == 0) ? CHECK : ACC;
                end
            end
            ACC: begin
                if (tick) begin
                    acc_nx = acc + stable_ext;
                    n_nx   = n + 1'b1;
                    if (n_nx == N_LAST) begin
                        state_nx = CHECK;
                    end
                end
            end
            CHECK: begin
                if (upd) begin
                    level_nx = avg;
                    valid_nx = 1'b1;
                    first_nx = 1'b0;
                    state_nx = EMIT;
                end else begin
                    state_nx = WAIT;
                end
            end
            EMIT: begin
                state_nx = WAIT;
            end
            default: begin
                state_nx = WAIT;
            end
        endcase
    end

    assign busy = (state == ACC);

endmodule

// File: tb/tb_pot_conditioner.sv
// ----------------------------------------------------------------------------
// tb_pot_conditioner
// Directed bench for pot_conditioner with SAMPLE_LOG2=4, AVG_LOG2=2,
// STABLE_CYCLES=4, HYST=16. Ticks fall on edges 16, 32, 48, ... after reset
// release, so every block spans 64 edges and its valid appears after edge
// 64*b+1. Raw values are changed 1 ns after an edge and reach `stable` seven
// edges later, well before the next sample.
// ----------------------------------------------------------------------------
module tb_pot_conditioner;

    logic        osc;
    logic        rst_n;
    logic [15:0] raw;
    logic [15:0] level;
    logic        valid;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;
    int ecnt     = 0;

    pot_conditioner #(
        .OUTSIZE       (16),
        .SAMPLE_LOG2   (4),
        .AVG_LOG2      (2),
        .STABLE_CYCLES (4),
        .HYST          (16)
    ) dut (
        .osc   (osc),
        .rst_n (rst_n),
        .raw   (raw),
        .level (level),
        .valid (valid),
        .busy  (busy)
    );

    initial begin
        osc = 1'b0;
        forever #5 osc = ~osc;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge osc);
        #1;
        ecnt++;
    endtask

    // Runs one block: v0..v3 are the values presented for the four samples
    // (or a per-cycle toggle when tog is set). Ends at the edge where the
    // block's valid would appear.
    task automatic run_block(input string name,
                             input logic [15:0] v0, input logic [15:0] v1,
                             input logic [15:0] v2, input logic [15:0] v3,
                             input bit tog, input int n_edges,
                             input bit exp_v, input logic [15:0] exp_lvl);
        int          vcnt;
        int          bcnt;
        int          lchg;
        int          phase;
        logic [15:0] prev;
        logic        vlast;
        vcnt  = 0;
        bcnt  = 0;
        lchg  = 0;
        vlast = 1'b0;
        prev  = level;
        raw   = tog ? 16'hAAAA : v0;
        for (int i = 1; i <= n_edges; i++) begin
            step();
            phase = ecnt % 64;
            if (tog) begin
                raw = (i % 2 == 1) ? 16'h5555 : 16'hAAAA;
            end else if (phase == 16) begin
                raw = v1;
            end else if (phase == 32) begin
                raw = v2;
            end else if (phase == 48) begin
                raw = v3;
            end
            if (valid) vcnt++;
            if (busy)  bcnt++;
            if (level !== prev) lchg++;
            prev  = level;
            vlast = valid;
        end
        check_val({name, "_valid_cnt"}, vcnt, exp_v ? 1 : 0);
        check_val({name, "_valid_at_lat"}, vlast, exp_v);
        check_val({name, "_busy_cycles"}, bcnt, 48);
        check_val({name, "_level_chg"}, lchg, exp_v ? 1 : 0);
        check_val({name, "_level"}, level, exp_lvl);
    endtask

    initial begin
        rst_n = 1'b0;
        raw   = 16'h8000;
        #23;
        check_val("rst_level", level, 16'h0000);
        check_val("rst_valid", valid, 1'b0);
        check_val("rst_busy",  busy,  1'b0);
        @(posedge osc);
        #1;
        rst_n = 1'b1;
        ecnt  = 0;

        run_block("first",  16'h8000, 16'h8000, 16'h8000, 16'h8000, 1'b0, 65, 1'b1, 16'h8000);
        run_block("below",  16'h8008, 16'h8008, 16'h8008, 16'h8008, 1'b0, 64, 1'b0, 16'h8000);
        run_block("at_hyst",16'h8010, 16'h8010, 16'h8010, 16'h8010, 1'b0, 64, 1'b0, 16'h8000);
        run_block("above",  16'h8020, 16'h8020, 16'h8020, 16'h8020, 1'b0, 64, 1'b1, 16'h8020);
        run_block("down",   16'h7FF0, 16'h7FF0, 16'h7FF0, 16'h7FF0, 1'b0, 64, 1'b1, 16'h7FF0);
        run_block("avg4",   16'h0100, 16'h0200, 16'h0300, 16'h0400, 1'b0, 64, 1'b1, 16'h0280);
        run_block("hold",   16'h0280, 16'h0280, 16'h0280, 16'h0280, 1'b0, 64, 1'b0, 16'h0280);
        run_block("toggle", 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b1, 64, 1'b0, 16'h0280);
        run_block("max",    16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b0, 64, 1'b1, 16'hFFFF);
        run_block("min",    16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 64, 1'b1, 16'h0000);
        run_block("mid",    16'h5678, 16'h5678, 16'h5678, 16'h5678, 1'b0, 64, 1'b1, 16'h5678);

        // Partial block interrupted by reset after two ticks.
        raw = 16'h1234;
        repeat (40) step();
        check_val("pre_rst_busy",  busy,  1'b1);
        check_val("pre_rst_level", level, 16'h5678);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("async_rst_level", level, 16'h0000);
        check_val("async_rst_valid", valid, 1'b0);
        check_val("async_rst_busy",  busy,  1'b0);
        repeat (3) @(posedge osc);
        #1;
        rst_n = 1'b1;
        ecnt  = 0;
        run_block("post_rst", 16'h1234, 16'h1234, 16'h1234, 16'h1234, 1'b0, 65, 1'b1, 16'h1234);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
